mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Two-requester arbiter and access sequencer for the single external-memory port. The instruction-fetch path and the load/store data path each raise a request. The block grants one at a time, drives the memory address/write signals for a fixed number of wait states, then returns read data with a one-cycle acknowledge. It sits between the control unit / address handler and the external memory, and replaces direct shared-port muxing.

## Interface
Parameters:
- AW, 10, address width (matches instruction/data address buses)
- DW, 32, data width
- WAIT_STATES, 1, extra BUSY cycles per access (0..15)
- STARVE_MAX, 4, consecutive data grants tolerated while fetch waits (1..15)

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- if_req  in  1  fetch request, held until if_ack
- if_addr  in  AW  fetch address, stable while if_req
- if_ack  out  1  one-cycle fetch completion pulse
- dt_req  in  1  data request, held until dt_ack
- dt_we  in  1  data write (1) / read (0)
- dt_addr  in  AW  data address
- dt_wdata  in  DW  data write value
- dt_ack  out  1  one-cycle data completion pulse
- rd_data  out  DW  read data, valid in the ack cycle
- mem_en  out  1  memory access active
- mem_we  out  1  memory write enable
- mem_addr  out  AW  memory address
- mem_wdata  out  DW  memory write data
- mem_rdata  in  DW  memory read data
- owner  out  1  current/last grant: 0 = fetch, 1 = data
- busy  out  1  high in BUSY and ACK

## Operation
- FSM states are IDLE, BUSY, ACK.
- IDLE: sample requests.
  - No request: stay in IDLE.
  - One request: grant it.
  - Both requests: grant data, unless the starvation rule selects fetch.
  - On grant, register owner, mem_addr, mem_we (fetch: 0; data: dt_we) and mem_wdata (fetch: 0). Set mem_en=1. Load wait counter with WAIT_STATES. Go to BUSY.
- BUSY: mem_* outputs held constant.
  - Counter nonzero: decrement.
  - Counter zero: capture mem_rdata into rd_data, drop mem_en and mem_we, go to ACK.
- ACK: pulse the owner's ack for exactly one cycle. rd_data holds its value until the next capture. Requests are ignored in ACK. Next state is IDLE.
- Writes also pass through ACK. rd_data then carries whatever mem_rdata showed on the final BUSY cycle; requesters ignore it.
- Starvation counter (4 bits):
  - Increments on each data grant made while if_req is high.
  - Saturates at STARVE_MAX.
  - Clears on any fetch grant.
  - When both requests are present and the counter equals STARVE_MAX, fetch is granted.
- A request dropped before it is granted is never serviced.
- A request dropped during BUSY still completes, and its ack still pulses.
- Any reset assertion, including mid-access, forces IDLE and abandons the access. No ack is produced.

## Timing
- Reset values: if_ack=0, dt_ack=0, rd_data=0, mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0, owner=0, busy=0. Starvation counter = 0.
- Request first seen high in IDLE at cycle N:
  - BUSY occupies cycles N+1 .. N+1+WAIT_STATES.
  - ack and rd_data are valid in cycle N+2+WAIT_STATES.
- Back-to-back accesses: the next grant happens in the IDLE cycle N+3+WAIT_STATES. Peak throughput is one access per WAIT_STATES+3 cycles.
- Memory contract: mem_rdata is valid by the final BUSY cycle (WAIT_STATES+1 cycles after mem_addr is driven).
- Requester contract: deassert req on the clock edge ending the ack cycle, or keep it high with new operands for a following access.
- Grant decisions use registered state only. No combinational path exists from req to mem_* or to ack.

## Configuration
- ARB_FAIR_EN:
  - Defined: starvation counter and fetch-override rule are compiled in as described.
  - Undefined: counter logic is removed, and data always wins simultaneous requests (strict priority). All other behaviour and timing are identical.

## Test plan
- Reset then single fetch: WAIT_STATES=1, if_req with if_addr=0x01A at cycle 0, mem_rdata=0xDEADBEEF. Required: mem_en in cycles 1–2, if_ack pulse in cycle 3 with rd_data=0xDEADBEEF, dt_ack=0 throughout.
- Data write: dt_req, dt_we=1, dt_addr=0x3FF, dt_wdata=0x12345678. Required: mem_we=1 with mem_addr=0x3FF and mem_wdata=0x12345678 for 2 cycles, then dt_ack pulse, then mem_we=0.
- Simultaneous requests, ARB_FAIR_EN off: if_req and dt_req held continuously for 10 accesses. Required: 10 dt_ack pulses and 0 if_ack pulses.
- Starvation, ARB_FAIR_EN on, STARVE_MAX=4: both requests held continuously. Required: grant pattern D,D,D,D,F repeating, owner matching each grant.
- Mid-access reset: assert reset during the second BUSY cycle of a data read. Required: all outputs zero asynchronously and no dt_ack. After release with dt_req still high, a fresh access completes with ack WAIT_STATES+2 cycles later.
- WAIT_STATES=0 back-to-back fetch: if_req held with a new address each access. Required: if_ack every 3 cycles, each rd_data matching the addressed word.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Fetch/data arbiter and wait-state sequencer for the single external memory port.
// Define ARB_FAIR_EN to compile in the fetch anti-starvation counter; otherwise data has priority.
module mem_port_arbiter #(
    parameter int unsigned AW          = 10,
    parameter int unsigned DW          = 32,
    parameter int unsigned WAIT_STATES = 1,
    parameter int unsigned STARVE_MAX  = 4
) (
    input  logic          i_clock,
    input  logic          i_reset_n,
    input  logic          i_if_req,
    input  logic [AW-1:0] i_if_addr,
    output logic          o_if_ack,
    input  logic          i_dt_req,
    input  logic          i_dt_we,
    input  logic [AW-1:0] i_dt_addr,
    input  logic [DW-1:0] i_dt_wdata,
    output logic          o_dt_ack,
    output logic [DW-1:0] o_rd_data,
    output logic          o_mem_en,
    output logic          o_mem_we,
    output logic [AW-1:0] o_mem_addr,
    output logic [DW-1:0] o_mem_wdata,
    input  logic [DW-1:0] i_mem_rdata,
    output logic          o_owner,
    output logic          o_busy
);

    if (WAIT_STATES > 15 || STARVE_MAX < 1 || STARVE_MAX > 15) begin : g_bad_params
        $error("mem_port_arbiter: WAIT_STATES must be 0..15, STARVE_MAX 1..15");
    end

    typedef enum logic [1:0] {StIdle, StBusy, StAck} state_e;

    state_e        r_state, w_state_next;
    logic [3:0]    r_wait_cnt;
    logic          r_owner, r_mem_en, r_mem_we;
    logic [AW-1:0] r_mem_addr;
    logic [DW-1:0] r_mem_wdata, r_rd_data;
    logic          w_grant_any, w_grant_dt, w_fetch_ovr, w_wait_done;

    assign w_grant_any = i_if_req | i_dt_req;
    assign w_grant_dt  = i_dt_req & ~(i_if_req & w_fetch_ovr);
    assign w_wait_done = (r_wait_cnt == 4'd0);

`ifdef ARB_FAIR_EN
    logic [3:0] r_starve;

    assign w_fetch_ovr = (r_starve == 4'(STARVE_MAX));

    // Counts data grants that overtook a waiting fetch
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_starve <= 4'd0;
        end else if (r_state == StIdle && w_grant_any) begin
            if (!w_grant_dt) begin
                r_starve <= 4'd0;
            end else if (i_if_req && r_starve != 4'(STARVE_MAX)) begin
                r_starve <= r_starve + 4'd1;
            end
        end
    end
`else
    assign w_fetch_ovr = 1'b0;
`endif

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle:  if (w_grant_any) w_state_next = StBusy;
            StBusy:  if (w_wait_done) w_state_next = StAck;
            StAck:   w_state_next = StIdle;
            default: w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_wait_cnt  <= 4'd0;
            r_owner     <= 1'b0;
            r_mem_en    <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_rd_data   <= '0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (w_grant_any) begin
                        r_owner     <= w_grant_dt;
                        r_mem_en    <= 1'b1;
                        r_mem_we    <= w_grant_dt & i_dt_we;
                        r_mem_addr  <= w_grant_dt ? i_dt_addr : i_if_addr;
                        r_mem_wdata <= w_grant_dt ? i_dt_wdata : '0;
                        r_wait_cnt  <= 4'(WAIT_STATES);
                    end
                end
                StBusy: begin
                    if (w_wait_done) begin
                        r_rd_data <= i_mem_rdata;
                        r_mem_en  <= 1'b0;
                        r_mem_we  <= 1'b0;
                    end else begin
                        r_wait_cnt <= r_wait_cnt - 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        o_busy      = (r_state != StIdle);
        o_if_ack    = (r_state == StAck) & ~r_owner;
        o_dt_ack    = (r_state == StAck) & r_owner;
        o_owner     = r_owner;
        o_mem_en    = r_mem_en;
        o_mem_we    = r_mem_we;
        o_mem_addr  = r_mem_addr;
        o_mem_wdata = r_mem_wdata;
        o_rd_data   = r_rd_data;
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: vector table, hand sequences, ack scoreboards.
// dut0 runs WAIT_STATES=1, dut1 runs WAIT_STATES=0 for back-to-back fetches.
module tb_mem_port_arbiter;
    localparam int unsigned AW   = 10;
    localparam int unsigned DW   = 32;
    localparam int unsigned WS   = 1;
    localparam int unsigned SMAX = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic          if_req, dt_req, dt_we;
    logic [AW-1:0] if_addr, dt_addr, mem_addr;
    logic [DW-1:0] dt_wdata, rd_data, mem_wdata, mem_rdata;
    logic          if_ack, dt_ack, mem_en, mem_we, owner, busy;

    logic          if_req1;
    logic [AW-1:0] if_addr1, mem_addr1;
    logic [DW-1:0] rd_data1, mem_wdata1, mem_rdata1;
    logic          if_ack1, dt_ack1, mem_en1, mem_we1, owner1, busy1;

    function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
        if (a == 10'h01A) return 32'hDEADBEEF;
        return 32'hA5A5_0000 ^ {6'b0, a, 6'b0, a};
    endfunction

    assign mem_rdata  = mem_word(mem_addr);
    assign mem_rdata1 = mem_word(mem_addr1);

    mem_port_arbiter #(.AW(AW), .DW(DW), .WAIT_STATES(WS), .STARVE_MAX(SMAX)) dut0 (
        .i_clock(clk), .i_reset_n(rst_n),
        .i_if_req(if_req), .i_if_addr(if_addr), .o_if_ack(if_ack),
        .i_dt_req(dt_req), .i_dt_we(dt_we), .i_dt_addr(dt_addr), .i_dt_wdata(dt_wdata),
        .o_dt_ack(dt_ack), .o_rd_data(rd_data), .o_mem_en(mem_en), .o_mem_we(mem_we),
        .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata), .i_mem_rdata(mem_rdata),
        .o_owner(owner), .o_busy(busy)
    );

    mem_port_arbiter #(.AW(AW), .DW(DW), .WAIT_STATES(0), .STARVE_MAX(SMAX)) dut1 (
        .i_clock(clk), .i_reset_n(rst_n),
        .i_if_req(if_req1), .i_if_addr(if_addr1), .o_if_ack(if_ack1),
        .i_dt_req(1'b0), .i_dt_we(1'b0), .i_dt_addr('0), .i_dt_wdata('0),
        .o_dt_ack(dt_ack1), .o_rd_data(rd_data1), .o_mem_en(mem_en1), .o_mem_we(mem_we1),
        .o_mem_addr(mem_addr1), .o_mem_wdata(mem_wdata1), .i_mem_rdata(mem_rdata1),
        .o_owner(owner1), .o_busy(busy1)
    );

    int n_checks = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic          owner;
        logic [DW-1:0] rd;
    } sb_t;
    sb_t q0[$];
    sb_t q1[$];
    sb_t e0, e1;

    // Scoreboards: every ack pops the oldest expectation
    always @(negedge clk) begin
        if (if_ack || dt_ack) begin
            check("ack_exclusive", 64'(if_ack & dt_ack), 64'd0);
            if (q0.size() == 0) begin
                check("unexpected_ack", 64'(q0.size()), 64'd1);
            end else begin
                e0 = q0.pop_front();
                check("ack_kind", 64'(dt_ack), 64'(e0.owner));
                check("ack_owner", 64'(owner), 64'(e0.owner));
                check("ack_rd_data", 64'(rd_data), 64'(e0.rd));
            end
        end
    end

    always @(negedge clk) begin
        if (if_ack1 || dt_ack1) begin
            check("ws0_dt_ack", 64'(dt_ack1), 64'd0);
            if (q1.size() == 0) begin
                check("ws0_unexpected_ack", 64'(q1.size()), 64'd1);
            end else begin
                e1 = q1.pop_front();
                check("ws0_rd_data", 64'(rd_data1), 64'(e1.rd));
            end
        end
    end

    task automatic wait_ack(input int max_cyc, input logic exp_we, input logic [AW-1:0] exp_addr,
                            output int lat);
        lat = -1;
        for (int i = 1; i <= max_cyc; i++) begin
            @(negedge clk);
            if (if_ack || dt_ack) begin
                lat = i;
                break;
            end
            check("busy_mem_en", 64'(mem_en), 64'd1);
            check("busy_mem_we", 64'(mem_we), 64'(exp_we));
            check("busy_mem_addr", 64'(mem_addr), 64'(exp_addr));
        end
        check("ack_seen", 64'(if_ack | dt_ack), 64'd1);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_if_ack"}, 64'(if_ack), 64'd0);
        check({tag, "_dt_ack"}, 64'(dt_ack), 64'd0);
        check({tag, "_rd_data"}, 64'(rd_data), 64'd0);
        check({tag, "_mem_en"}, 64'(mem_en), 64'd0);
        check({tag, "_mem_we"}, 64'(mem_we), 64'd0);
        check({tag, "_mem_addr"}, 64'(mem_addr), 64'd0);
        check({tag, "_mem_wdata"}, 64'(mem_wdata), 64'd0);
        check({tag, "_owner"}, 64'(owner), 64'd0);
        check({tag, "_busy"}, 64'(busy), 64'd0);
    endtask

    typedef struct {
        logic          ifr;
        logic [AW-1:0] ia;
        logic          dtr;
        logic          we;
        logic [AW-1:0] da;
        logic [DW-1:0] wd;
        logic          own;
    } vec_t;
    vec_t vecs[6];

    logic [AW-1:0] addrs1[6];
    logic          exp_own;
    logic          exp_we;
    logic [AW-1:0] exp_addr;
    logic [DW-1:0] exp_wd;
    int            lat, n_ack, n_if, n_dt, exp_if, exp_dt, cycles, last_ack;
`ifdef ARB_FAIR_EN
    int            starve_model;
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{ifr: 1'b1, ia: 10'h01A, dtr: 1'b0, we: 1'b0, da: 10'h000, wd: 32'h0,
                    own: 1'b0};
        vecs[1] = '{ifr: 1'b0, ia: 10'h000, dtr: 1'b1, we: 1'b1, da: 10'h3FF, wd: 32'h12345678,
                    own: 1'b1};
        vecs[2] = '{ifr: 1'b0, ia: 10'h000, dtr: 1'b1, we: 1'b0, da: 10'h123, wd: 32'h0,
                    own: 1'b1};
        vecs[3] = '{ifr: 1'b1, ia: 10'h040, dtr: 1'b1, we: 1'b0, da: 10'h080, wd: 32'h0,
                    own: 1'b1};
        vecs[4] = '{ifr: 1'b1, ia: 10'h041, dtr: 1'b1, we: 1'b1, da: 10'h081, wd: 32'hCAFEF00D,
                    own: 1'b1};
        vecs[5] = '{ifr: 1'b1, ia: 10'h2AA, dtr: 1'b0, we: 1'b0, da: 10'h000, wd: 32'h0,
                    own: 1'b0};
        for (int k = 0; k < 6; k++) addrs1[k] = AW'(10'h010 + 7 * k);

        if_req = 0; if_addr = '0; dt_req = 0; dt_we = 0; dt_addr = '0; dt_wdata = '0;
        if_req1 = 0; if_addr1 = '0;

        // Reset state
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        check("reset_ws0_busy", 64'(busy1), 64'd0);
        check("reset_ws0_mem_en", 64'(mem_en1), 64'd0);
        rst_n = 1'b1;

        // Table-driven single accesses
        for (int k = 0; k < 6; k++) begin
            if_req = vecs[k].ifr; if_addr = vecs[k].ia;
            dt_req = vecs[k].dtr; dt_we = vecs[k].we;
            dt_addr = vecs[k].da; dt_wdata = vecs[k].wd;
            exp_we   = vecs[k].own & vecs[k].we;
            exp_addr = vecs[k].own ? vecs[k].da : vecs[k].ia;
            exp_wd   = vecs[k].own ? vecs[k].wd : '0;
            q0.push_back('{owner: vecs[k].own, rd: mem_word(exp_addr)});
            @(negedge clk);
            check("grant_mem_en", 64'(mem_en), 64'd1);
            check("grant_mem_we", 64'(mem_we), 64'(exp_we));
            check("grant_mem_addr", 64'(mem_addr), 64'(exp_addr));
            check("grant_mem_wdata", 64'(mem_wdata), 64'(exp_wd));
            check("grant_owner", 64'(owner), 64'(vecs[k].own));
            check("grant_busy", 64'(busy), 64'd1);
            wait_ack(8, exp_we, exp_addr, lat);
            check("ack_latency", 64'(lat), 64'(WS + 1));
            check("ack_mem_en", 64'(mem_en), 64'd0);
            check("ack_mem_we", 64'(mem_we), 64'd0);
            check("ack_busy", 64'(busy), 64'd1);
            if_req = 0; dt_req = 0; dt_we = 0;
            @(negedge clk);
            check("idle_busy", 64'(busy), 64'd0);
            check("idle_acks", 64'(if_ack | dt_ack), 64'd0);
        end

        // Both requests held for 10 accesses, counters start from reset
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        exp_if = 0; exp_dt = 0;
`ifdef ARB_FAIR_EN
        starve_model = 0;
`endif
        for (int k = 0; k < 10; k++) begin
`ifdef ARB_FAIR_EN
            if (starve_model == int'(SMAX)) begin
                exp_own = 1'b0;
                starve_model = 0;
            end else begin
                exp_own = 1'b1;
                starve_model++;
            end
`else
            exp_own = 1'b1;
`endif
            if (exp_own) exp_dt++; else exp_if++;
            q0.push_back('{owner: exp_own, rd: mem_word(exp_own ? 10'h200 : 10'h100)});
        end
        if_req = 1; if_addr = 10'h100; dt_req = 1; dt_we = 0; dt_addr = 10'h200;
        n_ack = 0; n_if = 0; n_dt = 0; cycles = 0;
        while (n_ack < 10 && cycles < 100) begin
            @(negedge clk);
            cycles++;
            if (if_ack || dt_ack) begin
                n_ack++;
                if (if_ack) n_if++;
                if (dt_ack) n_dt++;
                if (n_ack == 10) begin
                    if_req = 0; dt_req = 0;
                end
            end
        end
        check("simul_acks", 64'(n_ack), 64'd10);
        check("simul_if_acks", 64'(n_if), 64'(exp_if));
        check("simul_dt_acks", 64'(n_dt), 64'(exp_dt));
        check("simul_cycles", 64'(cycles), 64'((WS + 2) + 9 * (WS + 3)));
        @(negedge clk);
        check("simul_idle", 64'(busy), 64'd0);

        // Reset during the second BUSY cycle of a data read
        dt_req = 1; dt_we = 0; dt_addr = 10'h055;
        @(negedge clk);
        check("mr_busy1", 64'(busy), 64'd1);
        @(negedge clk);
        check("mr_busy2", 64'(busy), 64'd1);
        rst_n = 1'b0;
        #1;
        check_all_zero("midreset");
        @(negedge clk);
        check("mr_held_dt_ack", 64'(dt_ack), 64'd0);
        check("mr_held_busy", 64'(busy), 64'd0);
        rst_n = 1'b1;
        q0.push_back('{owner: 1'b1, rd: mem_word(10'h055)});
        wait_ack(8, 1'b0, 10'h055, lat);
        check("mr_ack_latency", 64'(lat), 64'(WS + 2));
        dt_req = 0;
        @(negedge clk);

        // WAIT_STATES=0, fetch held with a new address each access
        if_req1 = 1; if_addr1 = addrs1[0];
        q1.push_back('{owner: 1'b0, rd: mem_word(addrs1[0])});
        n_ack = 0; cycles = 0; last_ack = 0;
        while (n_ack < 6 && cycles < 60) begin
            @(negedge clk);
            cycles++;
            if (if_ack1) begin
                check("ws0_interval", 64'(cycles - last_ack), 64'(n_ack == 0 ? 2 : 3));
                last_ack = cycles;
                n_ack++;
                if (n_ack < 6) begin
                    if_addr1 = addrs1[n_ack];
                    q1.push_back('{owner: 1'b0, rd: mem_word(addrs1[n_ack])});
                end else begin
                    if_req1 = 0;
                end
            end
        end
        check("ws0_acks", 64'(n_ack), 64'd6);
        repeat (2) @(negedge clk);

        check("sb0_drained", 64'(q0.size()), 64'd0);
        check("sb1_drained", 64'(q1.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
